// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter for the shared synchronous-read data memory.
// A master may lock ownership for up to MAX_HOLD consecutive grants while the other waits.
module dbus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic                m0_lock,
    input  logic                m0_we,
    input  logic [DATA_W/8-1:0] m0_be,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic                m1_lock,
    input  logic                m1_we,
    input  logic [DATA_W/8-1:0] m1_be,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    generate
        if (MAX_HOLD < 1) begin : g_bad_cfg
            $error("dbus_arbiter: MAX_HOLD must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               rvalid_q, rvalid_d;
    logic               rsel_q, rsel_d;

    logic               g_any, g_sel;
    logic               idle_win, win_lock;
    logic               own, own_req, own_lock, oth_req, oth_lock, hold_ok;
    logic               sel_we;
    logic [BE_W-1:0]    sel_be;

    always_comb begin
        g_any      = 1'b0;
        g_sel      = 1'b0;
        state_d    = state_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        idle_win   = (m0_req && m1_req) ? ~last_q : m1_req;
        win_lock   = idle_win ? m1_lock : m0_lock;
        own        = (state_q == LOCK1);
        own_req    = own ? m1_req  : m0_req;
        own_lock   = own ? m1_lock : m0_lock;
        oth_req    = own ? m0_req  : m1_req;
        oth_lock   = own ? m0_lock : m1_lock;
        hold_ok    = (hold_cnt_q < CNT_W'(MAX_HOLD));

        // A released lock falls back to plain round-robin, which may re-lock the winner.
        if (state_q == IDLE || !own_lock) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
            if (m0_req || m1_req) begin
                g_any  = 1'b1;
                g_sel  = idle_win;
                last_d = idle_win;
                if (win_lock) begin
                    state_d    = idle_win ? LOCK1 : LOCK0;
                    hold_cnt_d = CNT_W'(1);
                end
            end
        end else if (own_req && (!oth_req || hold_ok)) begin
            g_any  = 1'b1;
            g_sel  = own;
            last_d = own;
            if (oth_req && hold_ok) begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
        end else if (oth_req) begin
            g_any      = 1'b1;
            g_sel      = ~own;
            last_d     = ~own;
            hold_cnt_d = '0;
            state_d    = !oth_lock ? IDLE : (own ? LOCK0 : LOCK1);
        end

        if (rst) begin
            g_any = 1'b0;
        end
    end

    assign sel_we    = g_sel ? m1_we : m0_we;
    assign sel_be    = g_sel ? m1_be : m0_be;
    assign mem_addr  = g_sel ? m1_addr : m0_addr;
    assign mem_wdata = g_sel ? m1_wdata : m0_wdata;
    assign mem_en    = g_any;
    assign mem_we    = (g_any && sel_we) ? sel_be : '0;
    assign m0_gnt    = g_any & ~g_sel;
    assign m1_gnt    = g_any & g_sel;

    assign rvalid_d  = g_any & ~sel_we;
    assign rsel_d    = g_sel;

    // Read return stage: data arrives from memory one cycle after the grant.
    assign m0_rvalid = rvalid_q & ~rsel_q & ~rst;
    assign m1_rvalid = rvalid_q & rsel_q & ~rst;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            hold_cnt_q <= '0;
            rvalid_q   <= 1'b0;
            rsel_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            rvalid_q   <= rvalid_d;
            rsel_q     <= rsel_d;
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: stimulus pushes expected grants/reads, a monitor pops them.
module tb_dbus_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_lock, m0_we, m0_gnt, m0_rvalid;
    logic [3:0]  m0_be;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_lock, m1_we, m1_gnt, m1_rvalid;
    logic [3:0]  m1_be;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          m;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gexp_t;

    typedef struct {
        int          m;
        logic [31:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_be(m0_be),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_be(m1_be),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
    endfunction

    // Synchronous-read memory model
    always @(posedge clk) begin
        if (mem_en && mem_we == 4'b0000) mem_rdata <= memfn(mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic req, input logic lock, input logic we,
                         input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            m0_req = req; m0_lock = lock; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_lock = lock; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic exp_g(input int m, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic want_r);
        gexp_t g;
        rexp_t r;
        g.m = m; g.we = we; g.be = be; g.addr = addr; g.wdata = wdata;
        gq.push_back(g);
        if (!we && want_r) begin
            r.m = m; r.data = memfn(addr);
            rq.push_back(r);
        end
    endtask

    task automatic do_reset();
        idle_all();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT grants or returns read data
    initial begin
        gexp_t ge;
        rexp_t re;
        forever begin
            @(negedge clk);
            if (m0_gnt && m1_gnt) chk("gnt_onehot", 32'({m1_gnt, m0_gnt}), 32'd1);
            if (m0_gnt || m1_gnt) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", 32'({m1_gnt, m0_gnt}), 32'd0);
                end else begin
                    ge = gq.pop_front();
                    chk("gnt_master", 32'(m1_gnt), 32'(ge.m));
                    chk("mem_en", 32'(mem_en), 32'd1);
                    chk("mem_we", 32'(mem_we), ge.we ? 32'(ge.be) : 32'd0);
                    chk("mem_addr", mem_addr, ge.addr);
                    if (ge.we) chk("mem_wdata", mem_wdata, ge.wdata);
                end
            end else begin
                chk("idle_mem_en", 32'(mem_en), 32'd0);
                chk("idle_mem_we", 32'(mem_we), 32'd0);
            end
            if (m0_rvalid || m1_rvalid) begin
                if (rq.size() == 0 || (m0_rvalid && m1_rvalid)) begin
                    chk("rvalid_unexpected", 32'({m1_rvalid, m0_rvalid}), 32'd0);
                end else begin
                    re = rq.pop_front();
                    chk("rvalid_master", 32'(m1_rvalid), 32'(re.m));
                    chk("rdata", re.m == 1 ? m1_rdata : m0_rdata, re.data);
                end
            end
        end
    end

    initial begin
        int seq_rr[6]  = '{0, 1, 0, 1, 0, 1};
        int seq_lk[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int seq_nh[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        int m1r_nh[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        int m;

        mem_rdata = 32'h0;
        rst = 1'b1;
        idle_all();
        // Reset gates grants and write enables even with both masters asking
        drive(0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b1, 4'hF, 32'hC, 32'h1234);
        step();
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        do_reset();

        // Single read from m0
        drive(0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h10, 32'h0);
        exp_g(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b1);
        #1;
        chk("rd_same_cycle_gnt", 32'(m0_gnt), 32'd1);
        step();
        idle_all();
        step();

        // Plain round-robin
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h20, 32'h0);
            drive(1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h24, 32'h0);
            exp_g(seq_rr[i], 1'b0, 4'h0, seq_rr[i] == 1 ? 32'h24 : 32'h20, 32'h0, 1'b1);
            step();
        end

        // Locked m0 bounded by MAX_HOLD
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
            drive(1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h34, 32'h0);
            exp_g(seq_lk[i], 1'b0, 4'h0, seq_lk[i] == 1 ? 32'h34 : 32'h30, 32'h0, 1'b1);
            step();
        end

        // Hold count advances only while the other master waits
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h70, 32'h0);
            drive(1, m1r_nh[i] == 1, 1'b0, 1'b0, 4'h0, 32'h74, 32'h0);
            exp_g(seq_nh[i], 1'b0, 4'h0, seq_nh[i] == 1 ? 32'h74 : 32'h70, 32'h0, 1'b1);
            step();
        end

        // Writes: tie with m0 write, then m1 read, then m1 write alone
        do_reset();
        drive(0, 1'b1, 1'b0, 1'b1, 4'b0011, 32'h200, 32'h11223344);
        drive(1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h204, 32'h0);
        exp_g(0, 1'b1, 4'b0011, 32'h200, 32'h11223344, 1'b1);
        step();
        drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        exp_g(1, 1'b0, 4'h0, 32'h204, 32'h0, 1'b1);
        step();
        drive(1, 1'b1, 1'b0, 1'b1, 4'b0100, 32'h104, 32'h00AB0000);
        exp_g(1, 1'b1, 4'b0100, 32'h104, 32'h00AB0000, 1'b1);
        step();
        idle_all();
        step();

        // Reset right after a read grant drops the pending rvalid
        do_reset();
        drive(0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h40, 32'h0);
        exp_g(0, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0);
        step();
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h44, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h48, 32'h0);
        #1;
        chk("rst_mid_rvalid_t1", 32'(m0_rvalid), 32'd0);
        chk("rst_mid_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
        step();
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h50, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h54, 32'h0);
        exp_g(0, 1'b0, 4'h0, 32'h50, 32'h0, 1'b1);
        #1;
        chk("rst_mid_rvalid_t2", 32'(m0_rvalid), 32'd0);
        step();
        drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        exp_g(1, 1'b0, 4'h0, 32'h54, 32'h0, 1'b1);
        step();

        // Lock released after two grants hands the next tie to m1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, i < 2, 1'b0, 4'h0, 32'h60, 32'h0);
            drive(1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h64, 32'h0);
            m = (i == 2) ? 1 : 0;
            exp_g(m, 1'b0, 4'h0, m == 1 ? 32'h64 : 32'h60, 32'h0, 1'b1);
            step();
        end

        idle_all();
        step();
        step();
        chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
        chk("rd_queue_drained", 32'(rq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
